// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bus: hazard inputs from the Y86-64 pipeline registers,
// stall/bubble controls, F-stage PC, status and performance counters.
// The pipeline side uses the master modport; the control unit uses slave.
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic [63:0]      start_pc;
    logic [63:0]      f_predPC;
    logic [3:0]       D_icode;
    logic [3:0]       E_icode;
    logic [3:0]       M_icode;
    logic [3:0]       E_dstM;
    logic [3:0]       d_srcA;
    logic [3:0]       d_srcB;
    logic             e_Cnd;
    logic [2:0]       m_stat;
    logic [2:0]       W_stat;

    logic [63:0]      F_predPC;
    logic             F_stall;
    logic             D_stall;
    logic             D_bubble;
    logic             E_bubble;
    logic             M_bubble;
    logic             W_stall;
    logic [2:0]       cpu_stat;
    logic             halted;
    logic [CNT_W-1:0] run_cycles;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] bubble_cycles;

    modport master (
        output start, start_pc, f_predPC,
        output D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd,
        output m_stat, W_stat,
        input  F_predPC, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        input  cpu_stat, halted, run_cycles, stall_cycles, bubble_cycles
    );

    modport slave (
        input  start, start_pc, f_predPC,
        input  D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB, e_Cnd,
        input  m_stat, W_stat,
        output F_predPC, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall,
        output cpu_stat, halted, run_cycles, stall_cycles, bubble_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control unit: owns the F-stage predicted-PC register,
// resolves load/use, ret, mispredict and exception hazards into per-stage
// stall/bubble controls, sequences IDLE/RUN/DONE and keeps saturating
// performance counters. Control outputs are purely combinational.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.slave    bus
);

    localparam logic [3:0] IC_MRMOVQ = 4'd5;
    localparam logic [3:0] IC_JXX    = 4'd7;
    localparam logic [3:0] IC_RET    = 4'd9;
    localparam logic [3:0] IC_POPQ   = 4'd11;
    localparam logic [3:0] RNONE     = 4'd15;
    localparam logic [2:0] STAT_AOK  = 3'd1;
    localparam logic [2:0] STAT_ADR  = 3'd2;
    localparam logic [2:0] STAT_INS  = 3'd3;
    localparam logic [2:0] STAT_HLT  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Exceptional status: address error, invalid instruction or halt.
    function automatic logic is_exc(input logic [2:0] s);
        return (s == STAT_ADR) || (s == STAT_INS) || (s == STAT_HLT);
    endfunction

    // Counter step that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != CNT_MAX))
            return v + CNT_ONE;
        return v;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [63:0]      r_F_predPC;
    logic [2:0]       r_cpu_stat;
    logic [CNT_W-1:0] r_run_cycles;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_bubble_cycles;

    logic w_lu;
    logic w_rt;
    logic w_mp;
    logic w_ex;
    logic w_w_exc;
    logic w_in_run;
    logic w_F_stall;
    logic w_D_stall;
    logic w_D_bubble;
    logic w_E_bubble;
    logic w_M_bubble;
    logic w_W_stall;

    // Hazard detection from the instructions currently held in D, E and M.
    always_comb begin
        w_lu    = 1'b0;
        w_rt    = 1'b0;
        w_mp    = 1'b0;
        w_ex    = 1'b0;
        w_w_exc = is_exc(bus.W_stat);
        w_lu    = ((bus.E_icode == IC_MRMOVQ) || (bus.E_icode == IC_POPQ)) &&
                  (bus.E_dstM != RNONE) &&
                  ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
        w_rt    = (bus.D_icode == IC_RET) || (bus.E_icode == IC_RET) ||
                  (bus.M_icode == IC_RET);
        w_mp    = (bus.E_icode == IC_JXX) && !bus.e_Cnd;
        w_ex    = is_exc(bus.m_stat) || w_w_exc;
    end

    // Next-state and per-stage controls; a stall in D always wins over a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_in_run    = 1'b0;
        w_F_stall   = 1'b1;
        w_D_stall   = 1'b0;
        w_D_bubble  = 1'b1;
        w_E_bubble  = 1'b1;
        w_M_bubble  = 1'b1;
        w_W_stall   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_in_run   = 1'b1;
                w_F_stall  = w_lu || w_rt;
                w_D_stall  = w_lu;
                w_D_bubble = w_mp || (!w_lu && w_rt);
                w_E_bubble = w_mp || w_lu;
                w_M_bubble = w_ex;
                w_W_stall  = w_w_exc;
                if (w_w_exc)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_F_stall  = 1'b1;
                w_D_stall  = 1'b1;
                w_D_bubble = 1'b0;
                w_E_bubble = 1'b1;
                w_M_bubble = 1'b1;
                w_W_stall  = 1'b1;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Run-state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // F-stage register: seeded by start, then follows fetch's prediction unless stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_F_predPC <= 64'd0;
        else if ((r_state == ST_IDLE) && bus.start)
            r_F_predPC <= bus.start_pc;
        else if (w_in_run && !w_F_stall)
            r_F_predPC <= bus.f_predPC;
    end

    // Processor status captured on the edge that leaves RUN for DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cpu_stat <= STAT_AOK;
        else if (w_in_run && w_w_exc)
            r_cpu_stat <= bus.W_stat;
    end

    // Saturating performance counters, advancing only in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_cycles    <= '0;
            r_stall_cycles  <= '0;
            r_bubble_cycles <= '0;
        end else begin
            r_run_cycles    <= sat_inc(r_run_cycles,    w_in_run);
            r_stall_cycles  <= sat_inc(r_stall_cycles,  w_in_run && w_F_stall);
            r_bubble_cycles <= sat_inc(r_bubble_cycles, w_in_run && w_E_bubble);
        end
    end

    assign bus.F_predPC      = r_F_predPC;
    assign bus.F_stall       = w_F_stall;
    assign bus.D_stall       = w_D_stall;
    assign bus.D_bubble      = w_D_bubble;
    assign bus.E_bubble      = w_E_bubble;
    assign bus.M_bubble      = w_M_bubble;
    assign bus.W_stall       = w_W_stall;
    assign bus.cpu_stat      = r_cpu_stat;
    assign bus.halted        = (r_state == ST_DONE);
    assign bus.run_cycles    = r_run_cycles;
    assign bus.stall_cycles  = r_stall_cycles;
    assign bus.bubble_cycles = r_bubble_cycles;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage Y86-64 pipeline. It owns the F-stage register (`F_predPC`) and generates the per-stage stall and bubble controls: load/use interlock, mispredicted-jump squash, `ret` PC wait, and exception drain. A run-state FSM sequences the processor: idle after reset, run after `start`, frozen once an exceptional status reaches write-back. Performance counters track run cycles, F-stage stalls and E-stage bubbles.

## Interface

Parameters:
- `CNT_W`, 32, width of each performance counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; honoured only in IDLE.
- `start_pc`  in  64  PC loaded into `F_predPC` on an accepted `start`.
- `f_predPC`  in  64  predicted PC from fetch.
- `D_icode`, `E_icode`, `M_icode`  in  4 each  icodes held in the D, E and M registers.
- `E_dstM`  in  4  load destination register in E.
- `d_srcA`, `d_srcB`  in  4 each  source registers decoded in D.
- `e_Cnd`  in  1  branch condition computed in E.
- `m_stat`, `W_stat`  in  3 each  status in M (after memory) and in W.
- `F_predPC`  out  64  F-stage register.
- `F_stall`, `D_stall`, `D_bubble`, `E_bubble`, `M_bubble`, `W_stall`  out  1 each  pipeline register controls.
- `cpu_stat`  out  3  latched processor status.
- `halted`  out  1  high in DONE.
- `run_cycles`, `stall_cycles`, `bubble_cycles`  out  CNT_W each  performance counters.

## Operation

- Encodings: icodes HALT=0, NOP=1, RRMOVQ=2, IRMOVQ=3, RMMOVQ=4, MRMOVQ=5, OPQ=6, JXX=7, CALL=8, RET=9, PUSHQ=10, POPQ=11. RNONE=15. Stat codes AOK=1, ADR=2, INS=3, HLT=4. "Exc(s)" means s ∈ {2,3,4}.

FSM states:
- IDLE: entered on reset.
  - Outputs: F_stall=1; D_bubble=E_bubble=M_bubble=1; D_stall=W_stall=0.
  - `start` moves to RUN and loads `F_predPC` ← `start_pc`.
- RUN: hazard logic drives all controls.
  - Exc(W_stat) moves to DONE and latches `cpu_stat` ← W_stat on the same edge.
  - `start` is ignored.
- DONE: sticky; only `rst` leaves it.
  - Outputs: F_stall=D_stall=W_stall=1; E_bubble=M_bubble=1; D_bubble=0.
  - `F_predPC` holds its value.

Hazard terms in RUN (combinational):
- `lu` (load/use) = (E_icode ∈ {MRMOVQ, POPQ}) ∧ E_dstM≠RNONE ∧ (E_dstM=d_srcA ∨ E_dstM=d_srcB).
- `rt` (ret pending) = RET ∈ {D_icode, E_icode, M_icode}.
- `mp` (mispredict) = E_icode=JXX ∧ ¬e_Cnd.
- `ex` (exception) = Exc(m_stat) ∨ Exc(W_stat).

Control equations in RUN:
- F_stall = lu ∨ rt.
- D_stall = lu.
- D_bubble = mp ∨ (¬lu ∧ rt). Stall has priority, so D_stall and D_bubble are never both 1.
- E_bubble = mp ∨ lu.
- M_bubble = ex.
- W_stall = Exc(W_stat).

F register:
- When F_stall=0 and the state is RUN, `F_predPC` ← `f_predPC`.
- When F_stall=1, `F_predPC` holds.

Counters (RUN cycles only):
- `run_cycles` increments every RUN cycle.
- `stall_cycles` increments when F_stall=1.
- `bubble_cycles` increments when E_bubble=1.
- All counters saturate at 2^CNT_W−1 and never wrap.
- All counters hold in IDLE and DONE.

## Timing

- Reset values: state=IDLE, `F_predPC`=0, `cpu_stat`=1 (AOK), `halted`=0, all counters 0.
- While `rst` is high, the control outputs show the IDLE values.
- Reset asserted mid-run returns to IDLE immediately, without waiting for a clock edge.
- Control outputs are combinational from the current inputs and state, and are valid in the same cycle. There is no internal register on the control path.
- `start` is sampled at a rising edge; the first RUN cycle follows that edge.
- The RUN→DONE edge coincides with the first cycle in which Exc(W_stat) holds. That cycle itself already drives W_stall=1 and M_bubble=1 and is counted in `run_cycles`.
- `halted` rises the cycle after that edge.
- `mp` and `lu` cannot occur together (E holds one instruction), so there are no further simultaneous-event rules beyond the D priority rule above.

## Test plan

- Reset, then no `start` for 5 cycles → F_stall=1, D_bubble=E_bubble=M_bubble=1, `F_predPC`=0, `run_cycles`=0.
- `start` with `start_pc`=0x100, then `f_predPC`=0x10A → after two edges `F_predPC`=0x10A and `run_cycles`=1.
- E_icode=5, E_dstM=3, d_srcB=3 → F_stall=D_stall=E_bubble=1 and D_bubble=0; with E_dstM=15 and d_srcA=15 → all controls 0.
- E_icode=7 with e_Cnd=0 → D_bubble=E_bubble=1, F_stall=0. Separately, D_icode=9 → F_stall=1, D_bubble=1; adding the load/use condition → D_stall=1, D_bubble=0.
- m_stat=2 → M_bubble=1 with the state still RUN. Next cycle W_stat=4 → W_stall=1; after the edge `halted`=1 and `cpu_stat`=4, and a later `start` has no effect.
- CNT_W=4 with E_bubble held at 1 for 20 RUN cycles → `bubble_cycles`=15, no wrap. `rst` mid-run → all counters read 0 immediately.
